// File: rtl/rr_arbiter4_pkg.sv
// Shared arbiter definitions: FSM state encoding, requester count, round-robin search.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package rr_arbiter4_pkg;

  // Number of requesters sharing the slot
  localparam int ARB_NREQ = 4;

  // Arbiter FSM states (2-bit encoding)
  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT   = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_t;

  // Round-robin search result: found flag plus winning index
  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } rr_pick_t;

  // Returns the first set request searching ptr+1, ptr+2, ptr+3 and finally ptr
  // itself. The loop runs from the farthest candidate towards the nearest so the
  // nearest set request is the last one assigned and therefore wins.
  function automatic rr_pick_t rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    rr_pick_t   res;
    logic [1:0] cand;
    res = '0;
    for (int i = ARB_NREQ; i >= 1; i--) begin
      cand = ptr + 2'(i);
      if (req[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter4_decoder2to4.sv
// 2-to-4 one-hot decoder with enable; drives the resource-slot select lines.
// Latency: combinational.
// Backpressure: none; output is zero whenever en is low.
module decoder2to4 (
  input  logic [1:0] a,
  input  logic       en,
  output logic [3:0] y
);

  // One-hot decode of a, gated by en
  always_comb begin
    y = '0;
    if (en) begin
      y[a] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Round-robin arbiter: 4 level requesters share one slot; grant locked until release.
// Latency: req sampled -> grant 1 cycle; release -> next grant >= 2 cycles (RELEASE + IDLE).
// Backpressure: en=0 blocks new grants and revokes the active one. Optional hold
// timeout (forced release + 1-cycle timeout pulse) is built when RR_ARB_TIMEOUT_EN is defined.
module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] grant_idx,
  output logic       grant_vld,
  output logic       timeout
);

  // The hold counter must be able to reach HOLD_MAX-1 without wrapping
  if ((2 ** CNT_W) <= HOLD_MAX) begin : g_cnt_w_check
    $error("rr_arbiter4: CNT_W too small for HOLD_MAX");
  end

  arb_state_t state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic       vld_q, vld_d;
  logic [1:0] ptr_q, ptr_d;
  logic       timeout_q, timeout_d;
  rr_pick_t   pick;

`ifdef RR_ARB_TIMEOUT_EN
  // Last cycle a grant may stay visible; a grant is therefore seen HOLD_MAX cycles
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Winner among the live requests, searching after the last owner
  assign pick = rr_pick(req, ptr_q);

  // Next-state, grant bookkeeping and timeout pulse
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    vld_d     = vld_q;
    ptr_d     = ptr_q;
    timeout_d = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        vld_d = 1'b0;
        // Only the request vector present at this edge is considered
        if (en && pick.found) begin
          idx_d   = pick.idx;
          ptr_d   = pick.idx;
          vld_d   = 1'b1;
          state_d = ARB_GRANT;
`ifdef RR_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ARB_GRANT: begin
`ifdef RR_ARB_TIMEOUT_EN
        cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
`endif
        // Owner release or enable drop takes priority over the hold timeout
        if (!req[idx_q] || !en) begin
          vld_d   = 1'b0;
          state_d = ARB_RELEASE;
        end
`ifdef RR_ARB_TIMEOUT_EN
        else if (cnt_q == HOLD_LAST) begin
          vld_d     = 1'b0;
          timeout_d = 1'b1;
          state_d   = ARB_RELEASE;
        end
`endif
      end
      ARB_RELEASE: begin
        // One dead cycle so two grants never touch
        vld_d   = 1'b0;
        state_d = ARB_IDLE;
      end
      default: begin
        vld_d   = 1'b0;
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State and grant registers; ptr resets to 3 so the first search starts at index 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      idx_q     <= 2'd0;
      vld_q     <= 1'b0;
      ptr_q     <= 2'd3;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      vld_q     <= vld_d;
      ptr_q     <= ptr_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  // Hold counter: cycles the current grant has been visible, minus one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign grant_idx = idx_q;
  assign grant_vld = vld_q;
  assign timeout   = timeout_q;

  // Slot select: one-hot of the registered winner, only while the grant is live
  decoder2to4 u_dec (
    .a  (idx_q),
    .en (vld_q),
    .y  (grant)
  );

endmodule
